// File: rtl/vga_plot_scheduler_if.sv
// Pixel-port arbitration bus between the load/draw controllers and the VGA plot scheduler.
//
// Handshake: iReqA/iReqB are level requests. They are held high until the matching
// oDoneA/oDoneB pulse and dropped in the following cycle. A request still high after
// that cycle counts as a new request. iClear is a single-cycle pulse. oClearDone and
// oDone* are single-cycle pulses that coincide with the last pixel of the operation.
// oX/oY/oColour carry a pixel only when oPlot is 1.
interface vga_plot_scheduler_if;
    logic       iReqA;
    logic [7:0] iXA;
    logic [6:0] iYA;
    logic [2:0] iColourA;
    logic       oDoneA;

    logic       iReqB;
    logic [7:0] iXB;
    logic [6:0] iYB;
    logic [2:0] iColourB;
    logic       oDoneB;

    logic       iClear;
    logic       oClearDone;

    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       oPlot;
    logic       oBusy;

    // Requester / stimulus side
    modport master (
        output iReqA, iXA, iYA, iColourA,
        output iReqB, iXB, iYB, iColourB,
        output iClear,
        input  oDoneA, oDoneB, oClearDone,
        input  oX, oY, oColour, oPlot, oBusy
    );

    // Scheduler side
    modport slave (
        input  iReqA, iXA, iYA, iColourA,
        input  iReqB, iXB, iYB, iColourB,
        input  iClear,
        output oDoneA, oDoneB, oClearDone,
        output oX, oY, oColour, oPlot, oBusy
    );
endinterface

// File: rtl/vga_plot_scheduler.sv
// VGA plot scheduler: shares one pixel-write port between two box requesters (A, B)
// and a full-screen clear. Boxes are emitted one pixel per clock, x varying fastest.
// Clear has priority, A/B alternate round-robin, and nothing is preempted.
// All outputs are registered; the pixel registers double as the clear scan position.
module vga_plot_scheduler #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int BOX_SIZE        = 4
) (
    input  logic                       iClock,
    input  logic                       iResetn,
    vga_plot_scheduler_if.slave        bus,
    output logic [1:0]                 dbg_state_o
);

    localparam int KB = $clog2(BOX_SIZE);
    localparam int CW = 2 * KB;
    localparam logic [CW-1:0] LAST_K = CW'((BOX_SIZE * BOX_SIZE) - 1);
    localparam logic [7:0]    X_LAST = 8'(X_SCREEN_PIXELS - 1);
    localparam logic [6:0]    Y_LAST = 7'(Y_SCREEN_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BOX   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       vis;
    } pix_t;

    // Pixel k of a box: sums one bit wider than the port so off-screen slots are detected
    // instead of wrapping; the port still carries the truncated sum.
    function automatic pix_t box_pixel(input logic [7:0] bx, input logic [6:0] by,
                                       input logic [CW-1:0] k);
        logic [8:0] xs;
        logic [7:0] ys;
        pix_t       p;
        xs    = {1'b0, bx} + 9'(k[KB-1:0]);
        ys    = {1'b0, by} + 8'(k[CW-1:KB]);
        p.x   = xs[7:0];
        p.y   = ys[6:0];
        p.vis = (xs < 9'(X_SCREEN_PIXELS)) && (ys < 8'(Y_SCREEN_PIXELS));
        return p;
    endfunction

    state_t        state_q, state_d;
    logic          pend_q, pend_d;      // clear requested and not yet started
    logic          rr_q, rr_d;          // 0: A wins a tie, 1: B wins a tie
    logic          own_b_q, own_b_d;    // current box belongs to B
    logic [7:0]    bx_q, bx_d;
    logic [6:0]    by_q, by_d;
    logic [2:0]    bc_q, bc_d;
    logic [CW-1:0] k_q, k_d;            // index of the box pixel currently on the outputs

    logic [7:0]    ox_q, ox_d;
    logic [6:0]    oy_q, oy_d;
    logic [2:0]    oc_q, oc_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_a_q, done_a_d;
    logic          done_b_q, done_b_d;
    logic          cdone_q, cdone_d;

    logic          want_clear;
    logic          grant_a;
    logic          grant_b;
    pix_t          pix;

    // Arbitration seen from IDLE: pending or same-cycle clear first, then round-robin A/B
    assign want_clear = pend_q | bus.iClear;
    assign grant_a    = !want_clear && bus.iReqA && (!bus.iReqB || !rr_q);
    assign grant_b    = !want_clear && bus.iReqB && (!bus.iReqA ||  rr_q);

    // Next-state and next-output logic; outputs return to zero whenever no pixel is emitted
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q | bus.iClear;
        rr_d     = rr_q;
        own_b_d  = own_b_q;
        bx_d     = bx_q;
        by_d     = by_q;
        bc_d     = bc_q;
        k_d      = k_q;
        ox_d     = '0;
        oy_d     = '0;
        oc_d     = '0;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        cdone_d  = 1'b0;
        pix      = box_pixel(bx_q, by_q, k_q);

        unique case (state_q)
            S_IDLE: begin
                if (want_clear) begin
                    // First clear pixel (0,0) goes out on the grant edge
                    state_d = S_CLEAR;
                    pend_d  = 1'b0;
                    plot_d  = 1'b1;
                    busy_d  = 1'b1;
                end else if (grant_a || grant_b) begin
                    state_d = S_BOX;
                    own_b_d = grant_b;
                    rr_d    = grant_a;
                    bx_d    = grant_b ? bus.iXB     : bus.iXA;
                    by_d    = grant_b ? bus.iYB     : bus.iYA;
                    bc_d    = grant_b ? bus.iColourB : bus.iColourA;
                    k_d     = '0;
                    pix     = box_pixel(bx_d, by_d, '0);
                    ox_d    = pix.x;
                    oy_d    = pix.y;
                    oc_d    = bc_d;
                    plot_d  = pix.vis;
                    busy_d  = 1'b1;
                end
            end

            S_BOX: begin
                if (k_q == LAST_K) begin
                    state_d = S_IDLE;
                end else begin
                    k_d      = k_q + CW'(1);
                    pix      = box_pixel(bx_q, by_q, k_d);
                    ox_d     = pix.x;
                    oy_d     = pix.y;
                    oc_d     = bc_q;
                    plot_d   = pix.vis;
                    busy_d   = 1'b1;
                    done_a_d = (k_d == LAST_K) && !own_b_q;
                    done_b_d = (k_d == LAST_K) &&  own_b_q;
                end
            end

            S_CLEAR: begin
                if ((ox_q == X_LAST) && (oy_q == Y_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    if (ox_q == X_LAST) begin
                        ox_d = '0;
                        oy_d = oy_q + 7'd1;
                    end else begin
                        ox_d = ox_q + 8'd1;
                        oy_d = oy_q;
                    end
                    plot_d  = 1'b1;
                    busy_d  = 1'b1;
                    cdone_d = (ox_d == X_LAST) && (oy_d == Y_LAST);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any operation in flight without a done pulse
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_q  <= S_IDLE;
            pend_q   <= 1'b0;
            rr_q     <= 1'b0;
            own_b_q  <= 1'b0;
            bx_q     <= '0;
            by_q     <= '0;
            bc_q     <= '0;
            k_q      <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            oc_q     <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            cdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            rr_q     <= rr_d;
            own_b_q  <= own_b_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            bc_q     <= bc_d;
            k_q      <= k_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            oc_q     <= oc_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            cdone_q  <= cdone_d;
        end
    end

    assign bus.oX         = ox_q;
    assign bus.oY         = oy_q;
    assign bus.oColour    = oc_q;
    assign bus.oPlot      = plot_q;
    assign bus.oBusy      = busy_q;
    assign bus.oDoneA     = done_a_q;
    assign bus.oDoneB     = done_b_q;
    assign bus.oClearDone = cdone_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Directed bench for vga_plot_scheduler: expected pixel streams are built per scenario
// into a queue and compared slot by slot, one sample 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_vga_plot_scheduler;

    localparam int W = 23;   // {x[8], y[7], colour[3], plot, doneA, doneB, clearDone, busy}
    localparam logic [W-1:0] M_ALL   = {W{1'b1}};
    localparam logic [W-1:0] M_XYCTL = {8'hFF, 7'h7F, 3'b000, 5'h1F};
    localparam logic [W-1:0] M_CTL   = 23'h00001F;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_cmp;
    int         n_fail;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];

    vga_plot_scheduler_if bus();

    vga_plot_scheduler #(
        .X_SCREEN_PIXELS(160),
        .Y_SCREEN_PIXELS(120),
        .BOX_SIZE       (4)
    ) dut (
        .iClock     (clk),
        .iResetn    (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pack(input logic [7:0] x, input logic [6:0] y,
                                          input logic [2:0] c, input logic p,
                                          input logic da, input logic db,
                                          input logic cd, input logic busy);
        return {x, y, c, p, da, db, cd, busy};
    endfunction

    function automatic logic [W-1:0] obs();
        return {bus.oX, bus.oY, bus.oColour, bus.oPlot,
                bus.oDoneA, bus.oDoneB, bus.oClearDone, bus.oBusy};
    endfunction

    // Expected-stream builders
    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('0);
            msk_q.push_back(M_CTL);
        end
    endtask

    task automatic push_box(input int x, input int y, input int c, input bit is_b);
        for (int k = 0; k < 16; k++) begin
            int   xs;
            int   ys;
            logic vis;
            logic last;
            xs   = x + (k % 4);
            ys   = y + (k / 4);
            vis  = (xs < 160) && (ys < 120);
            last = (k == 15);
            exp_q.push_back(pack(xs[7:0], ys[6:0], c[2:0], vis,
                                 last && !is_b, last && is_b, 1'b0, 1'b1));
            msk_q.push_back(vis ? M_ALL : M_XYCTL);
        end
        push_idle(1);
    endtask

    task automatic push_clear();
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                exp_q.push_back(pack(x[7:0], y[6:0], 3'd0, 1'b1, 1'b0, 1'b0,
                                     (x == 159) && (y == 119), 1'b1));
                msk_q.push_back(M_ALL);
            end
        end
        push_idle(1);
    endtask

    task automatic clear_inputs();
        bus.iReqA = 1'b0; bus.iXA = '0; bus.iYA = '0; bus.iColourA = '0;
        bus.iReqB = 1'b0; bus.iXB = '0; bus.iYB = '0; bus.iColourB = '0;
        bus.iClear = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: observed %h required %h", obs(), {W{1'b0}});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: observed %h required %h", obs(), {W{1'b0}});
        end
    endtask

    task automatic test_box_a();
        logic [W-1:0] e, m, prev;
        int n;
        prev = '0;
        push_box(10, 20, 5, 1'b0);
        push_idle(2);
        n = exp_q.size();
        bus.iXA = 8'd10; bus.iYA = 7'd20; bus.iColourA = 3'd5; bus.iReqA = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL box_a slot %0d: observed %h required %h mask %h", i, obs(), e, m);
            end
            if (prev[3]) bus.iReqA = 1'b0;
            if (prev[2]) bus.iReqB = 1'b0;
            prev = e;
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] e, m, prev;
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        // Round 1: simultaneous requests after reset, A wins then B
        prev = '0;
        push_box(0, 0, 1, 1'b0);
        push_box(40, 50, 2, 1'b1);
        n = exp_q.size();
        bus.iXA = 8'd0;  bus.iYA = 7'd0;  bus.iColourA = 3'd1;
        bus.iXB = 8'd40; bus.iYB = 7'd50; bus.iColourB = 3'd2;
        bus.iReqA = 1'b1; bus.iReqB = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL rr_round1 slot %0d: observed %h required %h mask %h", i, obs(), e, m);
            end
            if (prev[3]) bus.iReqA = 1'b0;
            if (prev[2]) bus.iReqB = 1'b0;
            prev = e;
        end
        // Round 2: A alone moves the pointer to B, so the next tie goes to B
        prev = '0;
        push_box(100, 10, 3, 1'b0);
        push_idle(1);
        push_box(60, 70, 4, 1'b1);
        push_box(100, 10, 3, 1'b0);
        n = exp_q.size();
        bus.iXA = 8'd100; bus.iYA = 7'd10; bus.iColourA = 3'd3;
        bus.iXB = 8'd60;  bus.iYB = 7'd70; bus.iColourB = 3'd4;
        bus.iReqA = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL rr_round2 slot %0d: observed %h required %h mask %h", i, obs(), e, m);
            end
            if (prev[3]) bus.iReqA = 1'b0;
            if (prev[2]) bus.iReqB = 1'b0;
            if (i == 17) begin
                bus.iReqA = 1'b1;
                bus.iReqB = 1'b1;
            end
            prev = e;
        end
    endtask

    task automatic test_edge_clip();
        logic [W-1:0] e, m, prev;
        int n;
        prev = '0;
        push_box(158, 118, 3, 1'b1);
        push_idle(1);
        n = exp_q.size();
        bus.iXB = 8'd158; bus.iYB = 7'd118; bus.iColourB = 3'd3; bus.iReqB = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL edge_clip slot %0d: observed %h required %h mask %h", i, obs(), e, m);
            end
            if (prev[3]) bus.iReqA = 1'b0;
            if (prev[2]) bus.iReqB = 1'b0;
            prev = e;
        end
    endtask

    task automatic test_clear_mid_box();
        logic [W-1:0] e, m, prev;
        int n;
        prev = '0;
        push_box(20, 30, 6, 1'b0);
        push_clear();
        push_box(80, 90, 2, 1'b1);
        push_idle(1);
        n = exp_q.size();
        bus.iXA = 8'd20; bus.iYA = 7'd30; bus.iColourA = 3'd6;
        bus.iXB = 8'd80; bus.iYB = 7'd90; bus.iColourB = 3'd2;
        bus.iReqA = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL clear_mid_box slot %0d: observed %h required %h mask %h", i, obs(), e, m);
            end
            if (prev[3]) bus.iReqA = 1'b0;
            if (prev[2]) bus.iReqB = 1'b0;
            if (i == 5) bus.iClear = 1'b1;
            if (i == 6) bus.iClear = 1'b0;
            if (i == 8) bus.iReqB = 1'b1;
            prev = e;
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] e, m, prev;
        int n;
        bus.iXA = 8'd50; bus.iYA = 7'd60; bus.iColourA = 3'd7; bus.iReqA = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = pack(8'(50 + (i % 4)), 7'(60 + (i / 4)), 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL async_pre slot %0d: observed %h required %h", i, obs(), e);
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== '0) begin
            n_fail++;
            $display("FAIL async_immediate: observed %h required %h (state %0d)", obs(), {W{1'b0}}, dbg_state);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs() !== '0) begin
                n_fail++;
                $display("FAIL async_held cycle %0d: observed %h required %h", i, obs(), {W{1'b0}});
            end
        end
        rst_n = 1'b1;
        prev = '0;
        push_box(50, 60, 7, 1'b0);
        push_idle(1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL async_regrant slot %0d: observed %h required %h mask %h", i, obs(), e, m);
            end
            if (prev[3]) bus.iReqA = 1'b0;
            if (prev[2]) bus.iReqB = 1'b0;
            prev = e;
        end
    endtask

    task automatic test_double_clear();
        logic [W-1:0] e, m, prev;
        int n;
        prev = '0;
        push_clear();
        push_clear();
        push_box(1, 2, 4, 1'b0);
        push_idle(2);
        n = exp_q.size();
        bus.iXA = 8'd1; bus.iYA = 7'd2; bus.iColourA = 3'd4;
        bus.iClear = 1'b1;
        bus.iReqA  = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL double_clear slot %0d: observed %h required %h mask %h", i, obs(), e, m);
            end
            if (prev[3]) bus.iReqA = 1'b0;
            if (prev[2]) bus.iReqB = 1'b0;
            if (i == 0)    bus.iClear = 1'b0;
            if (i == 100)  bus.iClear = 1'b1;
            if (i == 101)  bus.iClear = 1'b0;
            if (i == 5000) bus.iClear = 1'b1;
            if (i == 5001) bus.iClear = 1'b0;
            prev = e;
        end
    endtask

    // Sequence and final report
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_box_a();
        test_round_robin();
        test_edge_clip();
        test_clear_mid_box();
        test_async_reset();
        test_double_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
